// File: rtl/down_counter_sched.sv
// rtl/down_counter_sched.sv - round-robin scheduler sharing one loadable down counter
//
// Grants a single down counter to one of NREQ requesters at a time, counts the
// owner's load value down to zero and returns a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   req       per-requester level request, held until the matching gnt rises
//   load_val  packed load values, requester i at [i*WIDTH +: WIDTH]
//   abort     cancels a countdown in progress (RUN only)
//   gnt       one-hot owner of the counter, zero when idle
//   done      one-cycle completion pulse to the owner
//   busy      counter owned
//   count     current counter value
module down_counter_sched #(
  parameter int WIDTH = 3,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] load_val,
  input  logic                  abort,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count
);

  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [WIDTH-1:0] count_q, count_d;

  logic [OW-1:0]    winner;
  logic [NREQ-1:0]  winner_oh;
  logic [WIDTH-1:0] win_load;

  // Index following the owner, wrapping at NREQ-1; the finished owner drops
  // to lowest priority for the next arbitration.
  function automatic logic [OW-1:0] ptr_after(input logic [OW-1:0] o);
    return (o == OW'(NREQ - 1)) ? '0 : o + 1'b1;
  endfunction

  // Round-robin search starting at ptr_q and wrapping through index 0.
  always_comb begin
    logic hit;
    int   idx;
    hit    = 1'b0;
    idx    = 0;
    winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && req[idx[OW-1:0]]) begin
        hit    = 1'b1;
        winner = idx[OW-1:0];
      end
    end
  end

  always_comb begin
    winner_oh = '0;
    win_load  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == OW'(i)) begin
        winner_oh[i] = 1'b1;
        win_load     = load_val[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = winner;
          gnt_d   = winner_oh;
          count_d = win_load;
          // A zero load skips RUN and completes straight away.
          if (win_load == '0) begin
            state_d = S_DONE;
            done_d  = winner_oh;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        // abort has priority over a countdown reaching zero on the same edge.
        if (abort) begin
          state_d = S_IDLE;
          gnt_d   = '0;
          count_d = '0;
          ptr_d   = ptr_after(owner_q);
        end else begin
          count_d = count_q - 1'b1;
          if (count_q == WIDTH'(1)) begin
            state_d = S_DONE;
            done_d  = gnt_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        ptr_d   = ptr_after(owner_q);
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = |gnt_q;
  assign count = count_q;

endmodule

// File: tb/tb_down_counter_sched.sv
// tb/tb_down_counter_sched.sv - scoreboard bench for down_counter_sched
module tb_down_counter_sched;

  localparam int W = 3;
  localparam int N = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] load_val;
  logic           abort;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic [W-1:0]   count;

  always #5 clk = ~clk;

  down_counter_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .load_val (load_val),
    .abort    (abort),
    .gnt      (gnt),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] gnt;
    logic [N-1:0] done;
    logic [W-1:0] count;
    logic         busy;
  } exp_t;

  exp_t sb[$];

  // Reference model of the scheduler, advanced once per rising edge.
  int           m_state, m_owner, m_ptr, m_count;
  logic [N-1:0] m_gnt, m_done;

  task automatic model_reset();
    m_state = M_IDLE; m_owner = 0; m_ptr = 0; m_count = 0;
    m_gnt = '0; m_done = '0;
  endtask

  task automatic model_edge();
    int w;
    if (!reset) begin
      model_reset();
      return;
    end
    m_done = '0;
    case (m_state)
      M_IDLE: begin
        if (req != '0) begin
          w = -1;
          for (int k = 0; k < N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
          m_owner = w;
          m_gnt   = '0;
          m_gnt[w] = 1'b1;
          m_count = int'((load_val >> (w * W)) & {{(N*W-W){1'b0}}, {W{1'b1}}});
          if (m_count == 0) begin
            m_state = M_DONE;
            m_done  = m_gnt;
          end else begin
            m_state = M_RUN;
          end
        end
      end
      M_RUN: begin
        if (abort) begin
          m_state = M_IDLE; m_gnt = '0; m_count = 0; m_ptr = (m_owner + 1) % N;
        end else begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_state = M_DONE;
            m_done  = m_gnt;
          end
        end
      end
      default: begin
        m_state = M_IDLE; m_gnt = '0; m_ptr = (m_owner + 1) % N;
      end
    endcase
  endtask

  // One clock: predict, push, let the edge happen, then pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    e.gnt = m_gnt; e.done = m_done; e.count = W'(m_count); e.busy = (m_gnt != '0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check_eq("gnt", gnt, e.gnt);
      check_eq("done", done, e.done);
      check_eq("count", count, e.count);
      check_eq("busy", busy, e.busy);
      check_eq("done_without_gnt", (done & ~gnt) != '0, 0);
      check_eq("done_multi", $countones(done) > 1, 0);
    end
  endtask

  task automatic do_reset();
    req = '0; abort = 1'b0; reset = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  int gcnt, dcnt, ng, ok;
  int order[4];
  logic [N-1:0] prev;

  initial begin
    reset = 1'b0; req = '0; abort = 1'b0; load_val = '0;
    model_reset();
    step(); step();
    check_eq("reset_gnt", gnt, 0);
    check_eq("reset_count", count, 0);
    reset = 1'b1;

    // 1: asynchronous reset mid-countdown
    req = 2'b01; load_val = {3'd0, 3'd5};
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      step();
      if (gnt == 2'b01 && count == 3'd3) ok = 1;
    end
    check_eq("t1_reach_count3", ok, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("t1_async_gnt", gnt, 0);
    check_eq("t1_async_done", done, 0);
    check_eq("t1_async_busy", busy, 0);
    check_eq("t1_async_count", count, 0);
    model_reset();
    step();
    reset = 1'b1;
    step();
    check_eq("t1_first_gnt", gnt, 2'b01);
    req = '0;
    for (int i = 0; i < 8; i++) step();

    // 2: single request, L=5
    do_reset();
    req = 2'b01; load_val = {3'd0, 3'd5};
    gcnt = 0; dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) req = '0;
      if (gnt[0]) gcnt++;
      if (done[0]) begin
        dcnt++;
        check_eq("t2_done_count", count, 0);
      end
    end
    check_eq("t2_gnt_cycles", gcnt, 6);
    check_eq("t2_done_cycles", dcnt, 1);

    // 3: round robin with both requests held
    do_reset();
    req = 2'b11; load_val = {3'd2, 3'd3};
    prev = '0; ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      step();
      if (gnt != '0 && prev == '0) begin
        order[ng] = gnt[1] ? 1 : 0;
        ng++;
      end
      prev = gnt;
    end
    check_eq("t3_grants", ng, 4);
    check_eq("t3_order0", order[0], 0);
    check_eq("t3_order1", order[1], 1);
    check_eq("t3_order2", order[2], 0);
    check_eq("t3_order3", order[3], 1);
    req = '0;
    for (int i = 0; i < 6; i++) step();

    // 4: zero load
    do_reset();
    req = 2'b01; load_val = {3'd0, 3'd0};
    step();
    req = '0;
    check_eq("t4_gnt", gnt, 2'b01);
    check_eq("t4_done", done, 2'b01);
    check_eq("t4_count", count, 0);
    step();
    check_eq("t4_idle_gnt", gnt, 0);
    step();

    // 5a: abort at count=2, next grant goes to requester 1
    do_reset();
    req = 2'b11; load_val = {3'd1, 3'd6};
    ok = 0; dcnt = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      step();
      if (done[0]) dcnt++;
      if (gnt == 2'b01 && count == 3'd2) ok = 1;
    end
    check_eq("t5_reach_count2", ok, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    if (done[0]) dcnt++;
    check_eq("t5_abort_gnt", gnt, 0);
    check_eq("t5_abort_count", count, 0);
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      step();
      if (gnt != '0) ok = 1;
    end
    check_eq("t5_next_owner", gnt, 2'b10);
    check_eq("t5_no_done0", dcnt, 0);
    req = '0;
    for (int i = 0; i < 4; i++) step();

    // 5b: abort coinciding with count=1
    do_reset();
    req = 2'b01; load_val = {3'd0, 3'd3};
    step();
    req = '0;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (count == 3'd1) ok = 1;
      else step();
    end
    check_eq("t5b_reach_count1", ok, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("t5b_done", done, 0);
    check_eq("t5b_gnt", gnt, 0);
    step();
    check_eq("t5b_done_late", done, 0);

    // 6: max load, no wrap
    do_reset();
    req = 2'b01; load_val = {3'd0, 3'd7};
    gcnt = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (i == 0) req = '0;
      if (gnt[0]) gcnt++;
    end
    check_eq("t6_gnt_cycles", gcnt, 8);
    check_eq("t6_final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
